max_pool_2x2: RTL
=================

# max_pool_2x2

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of the multi-channel convolution stage. It consumes the convolution's AXI-Stream of HEIGHT x WIDTH multi-channel activations and produces a (HEIGHT/2) x (WIDTH/2) stream. Each output element is the per-channel maximum of one non-overlapping 2x2 input block. A single half-row buffer holds the partial maxima, so the block needs no full-frame storage.

## Interface
- ACTIVATION_WIDTH, 8: bits per channel element.
- CHANNELS, 3: channels packed per beat; channel c occupies tdata[c*ACTIVATION_WIDTH +: ACTIVATION_WIDTH].
- HEIGHT, 600: input rows; must be even (elaboration error otherwise).
- WIDTH, 800: input columns; must be even (elaboration error otherwise).
- SIGNED, 1: 1 = two's-complement comparison, 0 = unsigned comparison.
- clock_i  in  1  sole clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-low reset (0 = reset).
- slave_tvalid_i  in  1  input beat valid.
- slave_tready_o  out  1  input beat accepted when high together with tvalid.
- slave_tdata_i  in  ACTIVATION_WIDTH*CHANNELS  input element, row-major order.
- slave_tlast_i  in  1  marks the last element of the input frame.
- master_tvalid_o  out  1  output beat valid.
- master_tready_i  in  1  downstream ready.
- master_tdata_o  out  ACTIVATION_WIDTH*CHANNELS  pooled element.
- master_tlast_o  out  1  marks the last pooled element of the frame.
- tlast_error_o  out  1  one-cycle pulse on an input tlast mismatch.

## Operation
- Counters: col (0..WIDTH-1) and row (0..HEIGHT-1) advance on each accepted input beat.
  - col wraps to 0 and increments row; row wraps to 0 after HEIGHT-1.
- Row buffer: WIDTH/2 entries of ACTIVATION_WIDTH*CHANNELS bits, single port, synchronous read (BRAM-inferable). Holding register h has the same width.
- Even row, even col: h <= pixel.
- Even row, odd col: rowbuf[col/2] <= max(h, pixel), per channel.
- Odd row, even col: h <= pixel; issue a read of rowbuf[col/2]. Its data is valid on the next odd-column beat, which is always at least one cycle later.
- Odd row, odd col: out <= max(rowbuf_rd, h, pixel), per channel. This loads the output register with master_tvalid_o = 1.
  - master_tlast_o = 1 iff row = HEIGHT-1 and col = WIDTH-1.
- Max is evaluated independently per channel. No widening, rounding or saturation: the result is always one of the inputs.
- Input tlast check:
  - tlast seen at any position other than (HEIGHT-1, WIDTH-1), or absent at that position, pulses tlast_error_o for one cycle.
  - An early tlast also forces row = col = 0 for the next beat, resynchronising to the next frame. Outputs already emitted stand; the partial block produces no output.
  - A missing tlast at the final position is only flagged; the counters wrap normally.
- Reset:
  - row, col, master_tvalid_o, master_tlast_o and tlast_error_o all reset to 0.
  - master_tdata_o, h and the row buffer are not reset. The row buffer is always rewritten on an even row before it is read.
  - A reset mid-frame abandons the frame; the next accepted beat is treated as (0,0).

## Timing
- slave_tready_o = reset_i & (~master_tvalid_o | master_tready_i). This combinational path from master_tready_i is allowed.
  - Non-emitting beats also stall while the output register is full and not draining.
- Latency: an output is valid on the cycle after the odd-row, odd-col input beat is accepted.
- Throughput: one input beat per cycle while downstream is ready; one output per 4 inputs.
- Output handshake:
  - master_tdata_o and master_tlast_o stay stable while master_tvalid_o & ~master_tready_i.
  - master_tvalid_o drops after a transfer unless a new emitting beat is accepted in the same cycle, in which case the register reloads back-to-back.
- tlast_error_o is registered and asserts the cycle after the offending beat.

## Test plan
- Unsigned smoke test (HEIGHT=WIDTH=4, CHANNELS=1, SIGNED=0): input 0..15 row-major, downstream always ready.
  - Outputs exactly 5, 7, 13, 15; tlast only on 15; tlast_error_o never pulses.
- Signed test (SIGNED=1, 4x4, all values negative, max placed in a different block corner each time): input block {-128,-3,-7,-100} -> output -3.
  - Repeat with the max in each of the 4 corner positions.
- Channel independence (CHANNELS=3): channel 0 max at top-left, channel 1 at top-right, channel 2 at bottom-right of the same block.
  - The output packs each channel's own max.
- Backpressure: random master_tready_i (30% high) plus random slave_tvalid_i gaps on a 6x8 frame.
  - Output sequence matches the model; tdata is stable while stalled; no beat is lost or duplicated.
- Early tlast: 4x4 frame with tlast on beat 9, then a full correct frame.
  - tlast_error_o pulses once; the first frame yields only 5 and 7; the second frame output is exact.
- Reset mid-frame: hold reset_i = 0 for 2 cycles after beat 6, then send a full frame.
  - Outputs are low during reset; the new frame's 4 outputs are correct.

Source files
------------

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max-pool over a row-major AXI-Stream of multi-channel activations.
// Partial maxima of each even row live in a half-row buffer; the odd row finishes each block.

module max_pool_2x2_lane #(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic [W-1:0] i_h,
    input  logic [W-1:0] i_px,
    input  logic [W-1:0] i_rd,
    output logic [W-1:0] o_max2,
    output logic [W-1:0] o_max3
);
    function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
        if (SIGNED) return $signed(a) > $signed(b);
        else        return a > b;
    endfunction

    assign o_max2 = gt(i_h, i_px) ? i_h : i_px;
    assign o_max3 = gt(i_rd, o_max2) ? i_rd : o_max2;
endmodule

module max_pool_2x2 #(
    parameter int ACTIVATION_WIDTH = 8,
    parameter int CHANNELS         = 3,
    parameter int HEIGHT           = 600,
    parameter int WIDTH            = 800,
    parameter bit SIGNED           = 1'b1
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic                                 slave_tvalid_i,
    output logic                                 slave_tready_o,
    input  logic [ACTIVATION_WIDTH*CHANNELS-1:0] slave_tdata_i,
    input  logic                                 slave_tlast_i,
    output logic                                 master_tvalid_o,
    input  logic                                 master_tready_i,
    output logic [ACTIVATION_WIDTH*CHANNELS-1:0] master_tdata_o,
    output logic                                 master_tlast_o,
    output logic                                 tlast_error_o
);
    localparam int DW = ACTIVATION_WIDTH * CHANNELS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

    if (HEIGHT % 2 != 0) begin : g_bad_height
        $error("max_pool_2x2: HEIGHT must be even");
    end
    if (WIDTH % 2 != 0) begin : g_bad_width
        $error("max_pool_2x2: WIDTH must be even");
    end

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [DW-1:0] r_h;
    logic [DW-1:0] r_rd;
    logic [DW-1:0] r_out;
    logic          r_mvalid;
    logic          r_mlast;
    logic          r_err;
    logic [DW-1:0] r_rowbuf [WIDTH/2];

    logic          w_accept;
    logic          w_last_pos;
    logic          w_emit;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_max2;
    logic [DW-1:0] w_max3;

    assign slave_tready_o = reset_i & (~r_mvalid | master_tready_i);
    assign w_accept       = slave_tvalid_i & slave_tready_o;
    assign w_last_pos     = (r_row == RW'(HEIGHT - 1)) && (r_col == CW'(WIDTH - 1));
    assign w_emit         = w_accept & r_row[0] & r_col[0];
    assign w_addr         = AW'(r_col >> 1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        max_pool_2x2_lane #(
            .W      (ACTIVATION_WIDTH),
            .SIGNED (SIGNED)
        ) u_lane (
            .i_h    (r_h[c*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]),
            .i_px   (slave_tdata_i[c*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]),
            .i_rd   (r_rd[c*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]),
            .o_max2 (w_max2[c*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]),
            .o_max3 (w_max3[c*ACTIVATION_WIDTH +: ACTIVATION_WIDTH])
        );
    end

    // An early tlast resynchronises to (0,0); a missing one only raises the flag.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_row <= '0;
            r_col <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && (slave_tlast_i != w_last_pos);
            if (w_accept) begin
                if (slave_tlast_i && !w_last_pos) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (r_col == CW'(WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == RW'(HEIGHT - 1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Single-port buffer: even rows write, odd rows read, so the two never collide.
    always_ff @(posedge clock_i) begin
        if (w_accept && !r_row[0] && r_col[0])
            r_rowbuf[w_addr] <= w_max2;
        else if (w_accept && r_row[0] && !r_col[0])
            r_rd <= r_rowbuf[w_addr];
    end

    always_ff @(posedge clock_i) begin
        if (w_accept && !r_col[0]) r_h <= slave_tdata_i;
        if (w_emit)                r_out <= w_max3;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
        end else if (w_emit) begin
            r_mvalid <= 1'b1;
            r_mlast  <= w_last_pos;
        end else if (master_tready_i) begin
            r_mvalid <= 1'b0;
        end
    end

    assign master_tvalid_o = r_mvalid;
    assign master_tdata_o  = r_out;
    assign master_tlast_o  = r_mlast;
    assign tlast_error_o   = r_err;
endmodule
